// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register for the 5-stage MIPS core.
// Captures GPR and HI/LO write-back from EX, and carries the multi-cycle
// MADD/MSUB intermediate state (partial product and step counter) back to EX.
module ex_mem #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_stall,
  input  logic          mem_stall,
  input  logic          flush,
  input  logic [AW-1:0] ex_w_reg_addr,
  input  logic [DW-1:0] ex_w_reg_data,
  input  logic          ex_w_reg_en,
  input  logic [DW-1:0] ex_hi,
  input  logic [DW-1:0] ex_lo,
  input  logic          ex_hilo_wen,
  input  logic [63:0]   ex_hilo_tmp,
  input  logic [1:0]    ex_cnt,
  output logic [AW-1:0] mem_w_reg_addr,
  output logic [DW-1:0] mem_w_reg_data,
  output logic          mem_w_reg_en,
  output logic [DW-1:0] mem_hi,
  output logic [DW-1:0] mem_lo,
  output logic          mem_hilo_wen,
  output logic [63:0]   hilo_tmp_out,
  output logic [1:0]    cnt_out
);

  logic [AW-1:0] w_reg_addr_reg;
  logic [DW-1:0] w_reg_data_reg;
  logic          w_reg_en_reg;
  logic [DW-1:0] hi_reg;
  logic [DW-1:0] lo_reg;
  logic          hilo_wen_reg;
  logic [63:0]   hilo_tmp_reg;
  logic [1:0]    cnt_reg;

  // Pipeline slot update: reset > flush > hold (mem_stall) > bubble (ex_stall) > advance.
  // A stalled MEM stage freezes everything regardless of ex_stall, so the
  // illegal ex_stall=0/mem_stall=1 combination also holds.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      w_reg_addr_reg <= '0;
      w_reg_data_reg <= '0;
      w_reg_en_reg   <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      hilo_wen_reg   <= 1'b0;
      hilo_tmp_reg   <= '0;
      cnt_reg        <= '0;
    end else if (mem_stall) begin
      w_reg_addr_reg <= w_reg_addr_reg;
      w_reg_data_reg <= w_reg_data_reg;
      w_reg_en_reg   <= w_reg_en_reg;
      hi_reg         <= hi_reg;
      lo_reg         <= lo_reg;
      hilo_wen_reg   <= hilo_wen_reg;
      hilo_tmp_reg   <= hilo_tmp_reg;
      cnt_reg        <= cnt_reg;
    end else if (ex_stall) begin
      // Bubble: enables and data cleared together; only the multi-cycle
      // op state moves so EX can pick up its first-cycle product.
      w_reg_addr_reg <= '0;
      w_reg_data_reg <= '0;
      w_reg_en_reg   <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      hilo_wen_reg   <= 1'b0;
      hilo_tmp_reg   <= ex_hilo_tmp;
      cnt_reg        <= ex_cnt;
    end else begin
      // Advance: copy EX results; any multi-cycle op has completed.
      w_reg_addr_reg <= ex_w_reg_addr;
      w_reg_data_reg <= ex_w_reg_data;
      w_reg_en_reg   <= ex_w_reg_en;
      hi_reg         <= ex_hi;
      lo_reg         <= ex_lo;
      hilo_wen_reg   <= ex_hilo_wen;
      hilo_tmp_reg   <= '0;
      cnt_reg        <= '0;
    end
  end

  assign mem_w_reg_addr = w_reg_addr_reg;
  assign mem_w_reg_data = w_reg_data_reg;
  assign mem_w_reg_en   = w_reg_en_reg;
  assign mem_hi         = hi_reg;
  assign mem_lo         = lo_reg;
  assign mem_hilo_wen   = hilo_wen_reg;
  assign hilo_tmp_out   = hilo_tmp_reg;
  assign cnt_out        = cnt_reg;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed scenarios plus randomized traffic against a
// slot-level reference model of the EX/MEM register.
module tb_ex_mem;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_stall, mem_stall, flush;
  logic [AW-1:0] ex_w_reg_addr;
  logic [DW-1:0] ex_w_reg_data;
  logic          ex_w_reg_en;
  logic [DW-1:0] ex_hi, ex_lo;
  logic          ex_hilo_wen;
  logic [63:0]   ex_hilo_tmp;
  logic [1:0]    ex_cnt;
  logic [AW-1:0] mem_w_reg_addr;
  logic [DW-1:0] mem_w_reg_data;
  logic          mem_w_reg_en;
  logic [DW-1:0] mem_hi, mem_lo;
  logic          mem_hilo_wen;
  logic [63:0]   hilo_tmp_out;
  logic [1:0]    cnt_out;

  always #5 clk = ~clk;

  ex_mem #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_stall(ex_stall), .mem_stall(mem_stall), .flush(flush),
    .ex_w_reg_addr(ex_w_reg_addr), .ex_w_reg_data(ex_w_reg_data), .ex_w_reg_en(ex_w_reg_en),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_wen(ex_hilo_wen),
    .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_w_reg_addr(mem_w_reg_addr), .mem_w_reg_data(mem_w_reg_data), .mem_w_reg_en(mem_w_reg_en),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo_wen(mem_hilo_wen),
    .hilo_tmp_out(hilo_tmp_out), .cnt_out(cnt_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference: what MEM should see, as one slot record plus the carried op state.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          en;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          hwen;
  } slot_t;

  slot_t       exp_slot;
  logic [63:0] exp_tmp;
  logic [1:0]  exp_cnt;
  int          hwen_pulses;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Predict the slot after the coming edge from the stage-level rules.
  task automatic predict();
    slot_t empty_slot;
    slot_t incoming;
    empty_slot = '{addr: '0, data: '0, en: 1'b0, hi: '0, lo: '0, hwen: 1'b0};
    incoming   = '{addr: ex_w_reg_addr, data: ex_w_reg_data, en: ex_w_reg_en,
                   hi: ex_hi, lo: ex_lo, hwen: ex_hilo_wen};
    if (rst_n === 1'b0 || flush) begin
      exp_slot = empty_slot; exp_tmp = 64'd0; exp_cnt = 2'd0;
    end else if (mem_stall) begin
      // MEM frozen: nothing moves
    end else if (ex_stall) begin
      exp_slot = empty_slot; exp_tmp = ex_hilo_tmp; exp_cnt = ex_cnt;
    end else begin
      exp_slot = incoming; exp_tmp = 64'd0; exp_cnt = 2'd0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".addr"}, 64'(mem_w_reg_addr), 64'(exp_slot.addr));
    check_val({tag, ".data"}, 64'(mem_w_reg_data), 64'(exp_slot.data));
    check_val({tag, ".en"},   64'(mem_w_reg_en),   64'(exp_slot.en));
    check_val({tag, ".hi"},   64'(mem_hi),         64'(exp_slot.hi));
    check_val({tag, ".lo"},   64'(mem_lo),         64'(exp_slot.lo));
    check_val({tag, ".hwen"}, 64'(mem_hilo_wen),   64'(exp_slot.hwen));
    check_val({tag, ".tmp"},  hilo_tmp_out,        exp_tmp);
    check_val({tag, ".cnt"},  64'(cnt_out),        64'(exp_cnt));
  endtask

  // One transaction: predict, clock, sample 1 time unit after the edge, compare.
  task automatic step(input string tag);
    predict();
    @(posedge clk);
    #1;
    if (mem_hilo_wen === 1'b1) hwen_pulses++;
    $display("[%0t] %s rst_n=%b fl=%b exs=%b mems=%b -> en=%b addr=%0d data=%h hwen=%b hi=%h lo=%h cnt=%0d tmp=%h",
             $time, tag, rst_n, flush, ex_stall, mem_stall, mem_w_reg_en, mem_w_reg_addr,
             mem_w_reg_data, mem_hilo_wen, mem_hi, mem_lo, cnt_out, hilo_tmp_out);
    compare_all(tag);
  endtask

  task automatic drive_slot(input logic [4:0] a, input logic [31:0] d, input logic en,
                            input logic [31:0] h, input logic [31:0] l, input logic hw);
    ex_w_reg_addr = a; ex_w_reg_data = d; ex_w_reg_en = en;
    ex_hi = h; ex_lo = l; ex_hilo_wen = hw;
  endtask

  initial begin
    exp_slot = '{addr: '0, data: '0, en: 1'b0, hi: '0, lo: '0, hwen: 1'b0};
    exp_tmp = '0; exp_cnt = '0; hwen_pulses = 0;

    // Reset with every input at all-ones
    rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0; mem_stall = 1'b0;
    drive_slot(5'h1F, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    ex_hilo_tmp = 64'hFFFF_FFFF_FFFF_FFFF; ex_cnt = 2'd3;
    #2;
    step("reset0");
    step("reset1");
    check_val("reset_data", 64'(mem_w_reg_data), 64'd0);
    check_val("reset_en", 64'(mem_w_reg_en), 64'd0);
    check_val("reset_cnt", 64'(cnt_out), 64'd0);
    rst_n = 1'b1;
    step("post_reset_adv");
    check_val("post_reset_data", 64'(mem_w_reg_data), 64'hFFFF_FFFF);

    // Advance
    drive_slot(5'd9, 32'h1234_5678, 1'b1, 32'hA, 32'hB, 1'b1);
    ex_cnt = 2'd0; ex_hilo_tmp = 64'd0;
    step("advance");
    check_val("adv_addr", 64'(mem_w_reg_addr), 64'd9);
    check_val("adv_data", 64'(mem_w_reg_data), 64'h1234_5678);
    check_val("adv_hi", 64'(mem_hi), 64'hA);
    check_val("adv_lo", 64'(mem_lo), 64'hB);
    check_val("adv_hwen", 64'(mem_hilo_wen), 64'd1);
    check_val("adv_cnt", 64'(cnt_out), 64'd0);

    // Bubble carrying MADD state
    ex_stall = 1'b1; ex_cnt = 2'd1; ex_hilo_tmp = 64'h0000_0001_8000_0000;
    step("bubble");
    check_val("bub_en", 64'(mem_w_reg_en), 64'd0);
    check_val("bub_hwen", 64'(mem_hilo_wen), 64'd0);
    check_val("bub_data", 64'(mem_w_reg_data), 64'd0);
    check_val("bub_cnt", 64'(cnt_out), 64'd1);
    check_val("bub_tmp", hilo_tmp_out, 64'h0000_0001_8000_0000);

    // Flush beats mem_stall
    flush = 1'b1; mem_stall = 1'b1;
    step("flush_stall");
    check_val("fl_cnt", 64'(cnt_out), 64'd0);
    check_val("fl_tmp", hilo_tmp_out, 64'd0);
    check_val("fl_data", 64'(mem_w_reg_data), 64'd0);
    flush = 1'b0; mem_stall = 1'b0; ex_stall = 1'b0;

    // Hold for three cycles
    drive_slot(5'd3, 32'h55, 1'b1, 32'h55, 32'h55, 1'b1);
    ex_cnt = 2'd0; ex_hilo_tmp = 64'd0;
    step("hold_load");
    ex_stall = 1'b1; mem_stall = 1'b1;
    drive_slot(5'd4, 32'hAA, 1'b1, 32'hAA, 32'hAA, 1'b1);
    ex_cnt = 2'd2; ex_hilo_tmp = 64'hAA;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check_val("hold_data", 64'(mem_w_reg_data), 64'h55);
      check_val("hold_en", 64'(mem_w_reg_en), 64'd1);
    end
    ex_stall = 1'b0; mem_stall = 1'b0;
    step("hold_release");
    check_val("release_data", 64'(mem_w_reg_data), 64'hAA);

    // Two-cycle MADD
    drive_slot(5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    ex_cnt = 2'd0; ex_hilo_tmp = 64'd0;
    step("madd_idle");
    hwen_pulses = 0;
    ex_stall = 1'b1; ex_cnt = 2'd1; ex_hilo_tmp = 64'h0000_0003_C000_0001;
    step("madd_n");
    check_val("madd_n1_cnt", 64'(cnt_out), 64'd1);
    check_val("madd_n1_tmp", hilo_tmp_out, 64'h0000_0003_C000_0001);
    check_val("madd_n1_hwen", 64'(mem_hilo_wen), 64'd0);
    ex_stall = 1'b0; ex_cnt = 2'd0; ex_hilo_tmp = 64'd0;
    drive_slot(5'd0, 32'd0, 1'b0, 32'h0000_0004, 32'hC000_0002, 1'b1);
    step("madd_n1");
    check_val("madd_n2_hwen", 64'(mem_hilo_wen), 64'd1);
    check_val("madd_n2_hi", 64'(mem_hi), 64'h4);
    check_val("madd_n2_lo", 64'(mem_lo), 64'hC000_0002);
    check_val("madd_n2_cnt", 64'(cnt_out), 64'd0);
    drive_slot(5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("madd_after");
    check_val("madd_hwen_pulses", 64'(hwen_pulses), 64'd1);

    // Reset mid-MADD
    ex_stall = 1'b1; ex_cnt = 2'd1; ex_hilo_tmp = 64'h77;
    step("madd_pre_rst");
    rst_n = 1'b0;
    step("madd_rst");
    check_val("madd_rst_cnt", 64'(cnt_out), 64'd0);
    rst_n = 1'b1; ex_stall = 1'b0; ex_cnt = 2'd0; ex_hilo_tmp = 64'd0;
    drive_slot(5'd7, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'h2, 1'b0);
    step("load_for_glitch");

    // Reset pulse between edges must be ignored
    mem_stall = 1'b1;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step("rst_glitch");
    check_val("glitch_data", 64'(mem_w_reg_data), 64'hDEAD_BEEF);
    mem_stall = 1'b0;

    // Randomized traffic, including the illegal ex_stall=0/mem_stall=1 pairing
    for (int i = 0; i < 300; i++) begin
      rst_n       = ($urandom_range(0, 31) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      ex_stall    = ($urandom_range(0, 3) == 0);
      mem_stall   = ($urandom_range(0, 4) == 0);
      drive_slot(5'($urandom), $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom));
      ex_hilo_tmp = {$urandom, $urandom};
      ex_cnt      = 2'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core. It captures the execute results each cycle: GPR write-back, HI/LO write-back, and the two-cycle multiply-accumulate intermediate state. It honours per-stage stall and global flush so that bubbles enter MEM correctly. Its registered HI/LO outputs are also the `mem_*` forwarding sources the execute stage reads.

## Interface
Parameters:
- AW, default `REG_ADDR_WIDTH (5): GPR address width.
- DW, default `REG_DATA_WIDTH (32): data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low; single clock domain.
- ex_stall  in  1  execute stage stalled this cycle.
- mem_stall  in  1  memory stage stalled this cycle.
- flush  in  1  exception/branch flush; clears the register.
- ex_w_reg_addr  in  AW  destination GPR from EX.
- ex_w_reg_data  in  DW  result from EX.
- ex_w_reg_en  in  1  GPR write enable from EX.
- ex_hi, ex_lo  in  DW  HI/LO values from EX.
- ex_hilo_wen  in  1  HI/LO write enable from EX.
- ex_hilo_tmp  in  64  partial product of a multi-cycle MADD/MSUB.
- ex_cnt  in  2  multi-cycle op step counter from EX.
- mem_w_reg_addr  out  AW  registered.
- mem_w_reg_data  out  DW  registered.
- mem_w_reg_en  out  1  registered.
- mem_hi, mem_lo  out  DW  registered; also the EX forwarding source.
- mem_hilo_wen  out  1  registered.
- hilo_tmp_out  out  64  fed back to EX.
- cnt_out  out  2  fed back to EX.

## Operation
All state updates on the rising clk edge. Priority per cycle, highest first:
1. **Reset** (rst_n=0): every output is 0.
2. **Flush** (flush=1): all pipeline outputs are 0, and hilo_tmp_out=0, cnt_out=0. Flush overrides both stalls.
3. **Bubble** (ex_stall=1, mem_stall=0):
   - Pipeline outputs are 0: w_reg_en=0, hilo_wen=0, and addr/data/hi/lo all zero.
   - hilo_tmp_out <= ex_hilo_tmp and cnt_out <= ex_cnt. This carries the multi-cycle op state.
4. **Hold** (mem_stall=1): all outputs, including hilo_tmp_out and cnt_out, keep their values.
   - ex_stall=1 with mem_stall=0 is the Bubble case above, not Hold.
   - ex_stall=0 with mem_stall=1 is illegal from the stall controller. The block treats it as Hold.
5. **Advance** (ex_stall=0, mem_stall=0):
   - Each pipeline output <= its ex_* counterpart.
   - hilo_tmp_out <= 0 and cnt_out <= 0, because the multi-cycle op has finished.

Further rules:
- No arithmetic is performed. All fields are copied width-for-width, with no sign extension.
- cnt_out and hilo_tmp_out are the only state that updates during a Bubble. EX uses them: cnt=1 means hilo_tmp holds the first-cycle product.
- Write enables and data are cleared together in a Bubble. A zero-enable slot never carries stale data.

## Timing
- Latency is 1 cycle from ex_* to mem_*. There is no combinational path from input to output.
- mem_hi/mem_lo/mem_hilo_wen are visible to EX forwarding in the cycle after EX produced them.
- Two-cycle MADD:
  - Cycle N: EX asserts ex_stall, ex_cnt=1 and ex_hilo_tmp=P.
  - Cycle N+1: cnt_out=1, hilo_tmp_out=P, mem_w_reg_en=0, mem_hilo_wen=0.
  - Cycle N+1: EX drops ex_stall and drives the final hi/lo with ex_hilo_wen=1.
  - Cycle N+2: mem_hilo_wen=1, cnt_out=0, hilo_tmp_out=0.
- Reset or flush asserted mid-MADD, in either cycle, clears cnt_out and hilo_tmp_out on that edge. The op is abandoned.
- flush and mem_stall asserted together: flush wins, and the outputs are zero next cycle.
- Reset is sampled only on clk edges. An asynchronous rst_n pulse between edges has no effect.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with all ex_* driven to 0xFFFF_FFFF/1 -> every output 0. Release, then advance -> mem_w_reg_data=0xFFFF_FFFF one cycle later.
- **Advance:** ex_w_reg_addr=5'd9, data=0x1234_5678, en=1, ex_hi=0xA, ex_lo=0xB, hilo_wen=1, no stalls -> the next cycle shows identical values on mem_*, with cnt_out=0.
- **Bubble:** drive the values above with ex_stall=1, mem_stall=0, ex_cnt=1, ex_hilo_tmp=0x0000_0001_8000_0000 -> mem_w_reg_en=0, mem_hilo_wen=0, data=0, cnt_out=1, hilo_tmp_out=0x0000_0001_8000_0000.
- **Hold:** after Advance with data 0x55, assert ex_stall=1 and mem_stall=1 for 3 cycles while changing ex_* to 0xAA -> outputs stay 0x55 and en=1 throughout. Release -> 0xAA appears.
- **Flush priority:** in the cycle after the Bubble (cnt_out=1), assert flush=1 together with mem_stall=1 -> all outputs 0 and cnt_out=0 next cycle.
- **MADD sequence:** run the two-cycle pattern from Timing -> mem_hilo_wen asserts exactly once, at N+2, with the final ex_hi/ex_lo, and cnt_out returns to 0.
